// File: rtl/mem_sync_pkg.sv
// Shared types and default widths for the synchronous-RAM initiator.
// Widths: 1024x8 memory, 10-bit burst length field.
package mem_sync_pkg;

  localparam int MEM_AW = 10;
  localparam int MEM_DW = 8;
  localparam int MEM_LW = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/mem_sync_master_if.sv
// Command/response and RAM pin bundle; master = initiator view, slave = environment view.
// Response side has no ready: it is never stalled.
interface mem_sync_master_if
  import mem_sync_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW,
  parameter int LW = MEM_LW
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          done;
  logic          mem_cs;
  logic          mem_wr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] mem_din;

  modport master (
    input  req_valid, req_we, req_addr, req_len, req_wdata, mem_din,
    output req_ready, rsp_valid, rsp_data, done,
           mem_cs, mem_wr, mem_rd, mem_addr, mem_dout
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len, req_wdata, mem_din,
    input  req_ready, rsp_valid, rsp_data, done,
           mem_cs, mem_wr, mem_rd, mem_addr, mem_dout
  );

endinterface

// File: rtl/mem_sync_agen.sv
// Burst beat counter plus wrapping address / data-seed incrementer; addr/wdata give the NEXT beat.
// Loaded on command accept, stepped once per issued beat; last_beat flags the beat currently driven.
module mem_sync_agen
  import mem_sync_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW,
  parameter int LW = MEM_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] start_addr,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] seed,
  output logic          last_beat,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata
);

  logic [LW-1:0] remain;

  // Address and data wrap naturally at their register widths.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remain <= '0;
      addr   <= '0;
      wdata  <= '0;
    end else if (load) begin
      remain <= len;
      addr   <= start_addr + AW'(1);
      wdata  <= seed + DW'(1);
    end else if (step) begin
      remain <= remain - LW'(1);
      addr   <= addr + AW'(1);
      wdata  <= wdata + DW'(1);
    end
  end

  assign last_beat = (remain == '0);

endmodule

// File: rtl/mem_sync_master.sv
// Single-port sync RAM initiator: first beat driven at accept edge, read data 2 cycles later, done closes each command.
// Bursts need MEM_SYNC_MASTER_BURST_EN; without it every command is one beat. Response port is never stalled.
module mem_sync_master
  import mem_sync_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW,
  parameter int LW = MEM_LW
) (
  input logic               clk,
  input logic               rst_n,
  mem_sync_master_if.master bus
);

  state_t        state, state_d;
  logic          cs_d, wr_d, rd_d, done_d, ready_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] dout_d;
  logic          accept, load, step, last_beat;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_wdata;
  logic          rd_pipe;

  assign accept = bus.req_valid && bus.req_ready;

`ifdef MEM_SYNC_MASTER_BURST_EN
  mem_sync_agen #(.AW(AW), .DW(DW), .LW(LW)) u_agen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (step),
    .start_addr (bus.req_addr),
    .len        (bus.req_len),
    .seed       (bus.req_wdata),
    .last_beat  (last_beat),
    .addr       (nxt_addr),
    .wdata      (nxt_wdata)
  );
`else
  logic [LW-1:0] unused_len;
  logic          unused_ctl;
  assign unused_len = bus.req_len;
  assign unused_ctl = load ^ step;
  assign last_beat  = 1'b1;
  assign nxt_addr   = bus.mem_addr;
  assign nxt_wdata  = bus.mem_dout;
`endif

  always_comb begin
    state_d = state;
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = bus.mem_addr;
    dout_d  = bus.mem_dout;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = bus.req_we ? WRITE : READ;
          cs_d    = 1'b1;
          wr_d    = bus.req_we;
          rd_d    = !bus.req_we;
          addr_d  = bus.req_addr;
          dout_d  = bus.req_wdata;
          load    = 1'b1;
        end
      end
      WRITE: begin
        if (last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cs_d   = 1'b1;
          wr_d   = 1'b1;
          addr_d = nxt_addr;
          dout_d = nxt_wdata;
          step   = 1'b1;
        end
      end
      READ: begin
        if (last_beat) begin
          state_d = DRAIN;
        end else begin
          cs_d   = 1'b1;
          rd_d   = 1'b1;
          addr_d = nxt_addr;
          step   = 1'b1;
        end
      end
      DRAIN: begin
        // Last read beat lands in rsp this same edge, so done lines up with it.
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.req_ready <= 1'b0;
      bus.mem_cs    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_rd    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_dout  <= '0;
      bus.done      <= 1'b0;
      rd_pipe       <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      state         <= state_d;
      bus.req_ready <= ready_d;
      bus.mem_cs    <= cs_d;
      bus.mem_wr    <= wr_d;
      bus.mem_rd    <= rd_d;
      bus.mem_addr  <= addr_d;
      bus.mem_dout  <= dout_d;
      bus.done      <= done_d;
      // RAM samples the strobe one edge later; rsp is registered one edge after that.
      rd_pipe       <= bus.mem_rd;
      bus.rsp_valid <= rd_pipe;
      bus.rsp_data  <= bus.mem_din;
    end
  end

endmodule

// File: doc/mem_sync_master.md
# mem_sync_master

Initiator for the single-port synchronous memory: accepts single or burst read/write commands over a valid/ready request port and drives the memory's `cs`/`wr`/`rd`/`addr`/`data` pins with correct one-cycle registered-read timing. Read data returns on an unstalled response port, and a `done` pulse closes every command. It sits between sequencing logic and the 1024x8 synchronous RAM and is the only block that drives the RAM's control pins.

## Interface
- `AW`, 10, address width (memory depth 2^AW)
- `DW`, 8, data width
- `LW`, 10, burst length field width (beats = `req_len`+1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  1  command valid
- `req_ready`  out  1  command accepted when `req_valid && req_ready` at a rising edge
- `req_we`  in  1  1 = write/fill, 0 = read
- `req_addr`  in  AW  start address
- `req_len`  in  LW  beats minus one
- `req_wdata`  in  DW  write seed
- `rsp_valid`  out  1  read beat valid, one cycle per beat
- `rsp_data`  out  DW  read beat data
- `done`  out  1  one-cycle pulse at command completion
- `mem_cs`, `mem_wr`, `mem_rd`  out  1  memory strobes
- `mem_addr`  out  AW  memory address
- `mem_dout`  out  DW  write data to memory
- `mem_din`  in  DW  memory `data_out`

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN. `req_ready` = 1 only in IDLE.
- On accept: latch `req_addr`, `req_len`, `req_wdata`, and `req_we`. Go to WRITE if `req_we`, else READ.
- WRITE:
  - One beat per cycle: `mem_cs`=`mem_wr`=1, `mem_rd`=0.
  - `mem_addr` = start + beat, wrapping modulo 2^AW (1023 -> 0).
  - `mem_dout` = `req_wdata` + beat, modulo 2^DW.
  - After the last beat, return to IDLE with `done`=1.
- READ:
  - One beat per cycle: `mem_cs`=`mem_rd`=1, `mem_wr`=0, with the same address wrap as WRITE.
  - After the last beat, go to DRAIN.
- DRAIN: wait until the last `rsp_valid`, then go to IDLE. `done` coincides with the last `rsp_valid`.
- Strobe rules:
  - `mem_wr` and `mem_rd` are never 1 together.
  - `mem_cs` = `mem_wr | mem_rd`.
  - Strobes are 0 in IDLE and DRAIN.
- `rsp_data` is `mem_din` registered. The response port has no backpressure.
- Beat counter is LW bits. `req_len`=2^LW-1 gives 1024 beats and covers the full memory exactly once.

## Timing
- All outputs are registered.
- Reset values: `req_ready`=0 during reset, then 1 in the first cycle after reset. All other outputs (`rsp_valid`, `rsp_data`, `done`, `mem_cs`, `mem_wr`, `mem_rd`, `mem_addr`, `mem_dout`) are 0.
- Accept at edge E0:
  - The first beat's strobes, address and data are driven from E0.
  - The memory samples them at E1.
  - For a read, `mem_din` is valid after E1, and `rsp_data`/`rsp_valid` are registered at E2.
- Read latency: the first `rsp_valid` goes high at E2. The N beats are contiguous and end at E(N+1).
- Write: beats drive E0..E(N-1). `done` and `req_ready` are high from E(N).
- Read: `done` and `req_ready` are high from E(N+1).
- Back-to-back: a command accepted in the `done` cycle starts the next cycle. There is no bubble beyond that.
- Reset mid-operation (`rst_n`=0 at any edge):
  - All outputs clear at that edge and the burst is abandoned.
  - In-flight read data is dropped: no `rsp_valid` and no `done` follow.
- `req_valid` while not ready is ignored; the command fields are not sampled.

## Configuration
- `MEM_SYNC_MASTER_BURST_EN` defined: `req_len` is honoured as described above.
- Not defined:
  - `req_len` is ignored and every command is exactly one beat; the beat counter is not built.
  - Write: strobe at E0, `done` at E1.
  - Read: `rsp_valid` and `done` at E2.

## Structure
- Shared package `mem_sync_pkg`:
  - FSM state enum (IDLE/WRITE/READ/DRAIN)
  - `MEM_AW`=10, `MEM_DW`=8 and `MEM_LW`=10 defaults
- Sub-module `mem_sync_agen`: beat counter plus wrapping address and data-seed incrementer. It outputs `last_beat`, `addr` and `wdata`. It is instantiated only under `MEM_SYNC_MASTER_BURST_EN`.

## Test plan
- Bench setup: master connected to a behavioural 1024x8 synchronous RAM. Every scenario is checked cycle-exact against the Timing section.
- Reset: hold `rst_n`=0 for 3 cycles -> all strobes, `rsp_valid` and `done` are 0; `req_ready`=1 in the first cycle after release.
- Single write then read:
  - Write addr 0x005, data 0xA5 -> `mem_wr` for 1 cycle, `done` at E1.
  - Read addr 0x005 -> `rsp_data`=0xA5 with `rsp_valid` at E2, coincident with `done`.
- Wrap fill: write addr 0x3FE, len 3, seed 0xFE -> addresses 0x3FE, 0x3FF, 0x000, 0x001 receive 0xFE, 0xFF, 0x00, 0x01.
- Read-back burst: read addr 0x3FE, len 3 -> 4 contiguous `rsp_valid` beats E2..E5 with the same 4 bytes; `done` at E5; `mem_rd` and `mem_wr` never both high.
- Reset mid-burst: read len 7, drop `rst_n` at E3 -> no further `rsp_valid` and no `done`; a fresh command after release behaves normally.
- Back-to-back: new write accepted in the `done` cycle of the previous read -> first `mem_wr` on the next cycle; `mem_cs`=0 in between only during DRAIN.
